apb_master_n: RTL

APB_MASTER_N -- requirements
Module: apb_master_n

---
 rtl/apb_pkg.sv | 39 +++
 rtl/apb_master_n_if.sv | 33 +++
 rtl/apb_addr_decoder.sv | 39 +++
 rtl/apb_master_n.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared FSM encoding, default address map and sizing helpers for
//            the N-slave APB master.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_decerr = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = c_st_idle,
        SETUP  = c_st_setup,
        ACCESS = c_st_access,
        DECERR = c_st_decerr
    } apb_state_e;

    localparam int          c_def_addr_w      = 32;
    localparam int          c_def_data_w      = 32;
    localparam int          c_def_num_slv     = 4;
    localparam logic [31:0] c_def_base_addr   = 32'h1000_0000;
    localparam logic [31:0] c_def_slv_size    = 32'h0000_1000;
    localparam int          c_def_timeout_cyc = 255;

    // Bits needed to hold 0..timeout_cyc; never less than one.
    function automatic int wait_cnt_width(input int timeout_cyc);
        int w = 1;
        while ((64'd1 << w) <= 64'(timeout_cyc)) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_n_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_n_if
// Brief    : Shared APB bus with per-slave select and response lanes.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_n_if import apb_pkg::*; #(
    parameter int ADDR_W  = c_def_addr_w,
    parameter int DATA_W  = c_def_data_w,
    parameter int NUM_SLV = c_def_num_slv
);

    logic [ADDR_W-1:0]              PADDR;
    logic [DATA_W-1:0]              PWDATA;
    logic                           PWRITE;
    logic                           PENABLE;
    logic [NUM_SLV-1:0]             PSEL;
    logic [NUM_SLV-1:0][DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]             PREADY;
    logic [NUM_SLV-1:0]             PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY, PSLVERR
    );

endinterface
`default_nettype wire

// File: rtl/apb_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : apb_addr_decoder
// Brief    : Combinational window decoder: address -> one-hot slave select.
// Revision : 1.0 - initial release
// ============================================================================
module apb_addr_decoder import apb_pkg::*; #(
    parameter int                ADDR_W    = c_def_addr_w,
    parameter int                NUM_SLV   = c_def_num_slv,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(c_def_base_addr),
    parameter logic [ADDR_W-1:0] SLV_SIZE  = ADDR_W'(c_def_slv_size)
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_sel,
    output logic               o_hit
);

    // Extra headroom so a window near the top of the address space cannot wrap.
    localparam int                 c_ext_w = ADDR_W + 5;
    localparam logic [c_ext_w-1:0] c_base  = c_ext_w'(BASE_ADDR);
    localparam logic [c_ext_w-1:0] c_size  = c_ext_w'(SLV_SIZE);

    logic [c_ext_w-1:0] w_addr_ext;

    assign w_addr_ext = c_ext_w'(i_addr);

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_win
            localparam logic [c_ext_w-1:0] c_lo = c_base + c_ext_w'(gi) * c_size;
            localparam logic [c_ext_w-1:0] c_hi = c_lo + c_size;

            assign o_sel[gi] = (w_addr_ext >= c_lo) && (w_addr_ext < c_hi);
        end
    endgenerate

    assign o_hit = |o_sel;

endmodule
`default_nettype wire

// File: rtl/apb_master_n.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_n
// Brief    : Core-to-APB bridge driving NUM_SLV slaves with address decode,
//            decode-error completion, wait timeout and back-to-back issue.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_n import apb_pkg::*; #(
    parameter int                ADDR_W      = c_def_addr_w,
    parameter int                DATA_W      = c_def_data_w,
    parameter int                NUM_SLV     = c_def_num_slv,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(c_def_base_addr),
    parameter logic [ADDR_W-1:0] SLV_SIZE    = ADDR_W'(c_def_slv_size),
    parameter int                TIMEOUT_CYC = c_def_timeout_cyc
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              transfer,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              error,
    apb_master_n_if.master    apb
);

    localparam int                  c_wait_w    = wait_cnt_width(TIMEOUT_CYC);
    localparam bit                  c_to_en     = (TIMEOUT_CYC != 0);
    localparam logic [c_wait_w-1:0] c_wait_last =
        c_wait_w'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    apb_state_e          r_state;
    logic [NUM_SLV-1:0]  r_sel;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_pwrite;
    logic [c_wait_w-1:0] r_wait;

    logic [NUM_SLV-1:0]  w_dec_sel;
    logic                w_dec_hit;
    logic                w_pready;
    logic                w_pslverr;
    logic [DATA_W-1:0]   w_prdata;
    logic                w_in_setup;
    logic                w_in_access;
    logic                w_in_decerr;
    logic                w_done;
    logic                w_timeout;
    logic                w_accept;
    apb_state_e          w_req_state;

    apb_addr_decoder #(
        .ADDR_W    (ADDR_W),
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .SLV_SIZE  (SLV_SIZE)
    ) u_dec (
        .i_addr (addr),
        .o_sel  (w_dec_sel),
        .o_hit  (w_dec_hit)
    );

    // Only the latched slave's lane reaches the response path.
    always_comb begin : p_resp_mux
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_pready  = w_pready  | (apb.PREADY[i]  & r_sel[i]);
            w_pslverr = w_pslverr | (apb.PSLVERR[i] & r_sel[i]);
            w_prdata  = w_prdata  | (apb.PRDATA[i]  & {DATA_W{r_sel[i]}});
        end
    end

    assign w_in_setup  = (r_state == SETUP);
    assign w_in_access = (r_state == ACCESS);
    assign w_in_decerr = (r_state == DECERR);
    assign w_done      = w_in_access && w_pready;
    assign w_timeout   = c_to_en && w_in_access && !w_pready && (r_wait == c_wait_last);

    // A timeout completion returns to IDLE and never takes a new request.
    assign w_accept    = transfer && ((r_state == IDLE) || w_done || w_in_decerr);
    assign w_req_state = w_dec_hit ? SETUP : DECERR;

    assign ready = w_done || w_timeout || w_in_decerr;
    assign error = (w_done && w_pslverr) || w_timeout || w_in_decerr;
    assign rdata = (w_done && !r_pwrite) ? w_prdata : '0;

    assign apb.PSEL    = (w_in_setup || w_in_access) ? r_sel : '0;
    assign apb.PENABLE = w_in_access;
    assign apb.PADDR   = r_paddr;
    assign apb.PWRITE  = r_pwrite;
    assign apb.PWDATA  = r_pwdata;

    always_ff @(posedge clk) begin : p_fsm
        if (reset) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_wait   <= '0;
        end else begin
            if (w_accept) begin
                r_paddr  <= addr;
                r_pwrite <= write;
                r_pwdata <= wdata;
                r_sel    <= w_dec_sel;
            end

            case (r_state)
                IDLE, DECERR: begin
                    r_state <= w_accept ? w_req_state : IDLE;
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_state <= w_accept ? w_req_state : IDLE;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_accept && w_dec_hit) begin
                r_wait <= '0;
            end else if (w_in_access && !w_pready) begin
                r_wait <= r_wait + c_wait_w'(1);
            end
        end
    end

endmodule
`default_nettype wire
